// File: rtl/bcd_serial_addsub.sv
// Serial multi-digit BCD adder/subtractor: one digit per clock, LSD first, through a shared +6-corrected digit adder.
// Optional macro BCD_DIGIT_CHECK_EN adds the err port flagging operand digits above 9.
module bcd_serial_addsub #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                sub,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                busy
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic                err
`endif
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned LAST  = DIGITS - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               sub_q, sub_d;
  logic               c_q, c_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
`ifdef BCD_DIGIT_CHECK_EN
  logic               err_q, err_d;
`endif

  // Shared digit adder; operands are shifted down so the current digit is always in [3:0]
  logic [3:0] a_dig, b_dig, bd, digit;
  logic [4:0] z;
  logic       carry;

  always_comb begin
    a_dig = a_q[3:0];
    b_dig = b_q[3:0];
    bd    = sub_q ? 4'(4'd9 - b_dig) : b_dig;
    z     = 5'(a_dig) + 5'(bd) + 5'(c_q);
    carry = (z > 5'd9);
    digit = carry ? 4'(z + 5'd6) : z[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      c_q         <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      c_q         <= c_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef BCD_DIGIT_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    c_d     = c_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef BCD_DIGIT_CHECK_EN
    err_d   = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          c_d     = sub ? ~cin : cin;
          idx_d   = '0;
`ifdef BCD_DIGIT_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[4*i +: 4] = digit;
        end
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        c_d   = carry;
        idx_d = idx_q + IDX_W'(1);
`ifdef BCD_DIGIT_CHECK_EN
        if ((a_dig > 4'd9) || (b_dig > 4'd9)) err_d = 1'b1;
`endif
        if (idx_q == IDX_W'(LAST)) begin
          cout_d  = sub_q ? ~carry : carry;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake flags follow the next state so they are registered alongside it
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef BCD_DIGIT_CHECK_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (DIGITS=4): decimal reference model plus directed vectors.
module tb_bcd_serial_addsub;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef BCD_DIGIT_CHECK_EN
  logic         err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_err;
  bit           exp_known = 1'b0;

  always #5 clk = ~clk;

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef BCD_DIGIT_CHECK_EN
    ,
    .err       (err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal reference: plain integer add/subtract modulo 10^DIGITS
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts, input logic tc,
                       output logic [W-1:0] s, output logic co, output logic er);
    int m = 1;
    int r;
    for (int i = 0; i < DIGITS; i++) m = m * 10;
    er = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if ((ta[4*i +: 4] > 4'd9) || (tb_v[4*i +: 4] > 4'd9)) er = 1'b1;
    if (!ts) begin
      r  = bcd2int(ta) + bcd2int(tb_v) + int'(tc);
      co = (r >= m);
      s  = int2bcd(r % m);
    end else begin
      r  = bcd2int(ta) - bcd2int(tb_v) - int'(tc);
      co = (r < 0);
      if (r < 0) r = r + m;
      s  = int2bcd(r);
    end
  endtask

  // Output checker: every cycle a result is presented it must match the model
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_valid_exclusive", 32'(in_ready & out_valid), 32'd0);
      if (out_valid) begin
        check("busy_in_done", 32'(busy), 32'd1);
        if (exp_known) begin
          check("model_sum", 32'(sum), 32'(exp_sum));
          check("model_cout", 32'(cout), 32'(exp_cout));
        end
`ifdef BCD_DIGIT_CHECK_EN
        check("model_err", 32'(err), 32'(exp_err));
`endif
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts, input logic tc,
                        input int hold, input bit known);
    int n;
    logic [W-1:0] ms;
    logic mc, me;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    a = ta; b = tb_v; sub = ts; cin = tc; in_valid = 1'b1;
    @(posedge clk);
    model(ta, tb_v, ts, tc, ms, mc, me);
    exp_sum = ms; exp_cout = mc; exp_err = me; exp_known = known;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'h7777; b = 16'h3333;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(DIGITS));
    if (!out_valid) return;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a = 16'h9999; b = 16'h8888; sub = ~ts;
      @(negedge clk);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
    check("post_hs_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef BCD_DIGIT_CHECK_EN
    check("rst_err", 32'(err), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 0, 1'b1);
    check("t1_sum", 32'(sum), 32'h6912);
    check("t1_cout", 32'(cout), 32'd0);

    run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 0, 1'b1);
    check("t2a_sum", 32'(sum), 32'h0000);
    check("t2a_cout", 32'(cout), 32'd1);

    run_op(16'h0000, 16'h0000, 1'b0, 1'b1, 0, 1'b1);
    check("t2b_sum", 32'(sum), 32'h0001);
    check("t2b_cout", 32'(cout), 32'd0);

    run_op(16'h0500, 16'h0123, 1'b1, 1'b0, 0, 1'b1);
    check("t3a_sum", 32'(sum), 32'h0377);
    check("t3a_cout", 32'(cout), 32'd0);

    run_op(16'h0123, 16'h0500, 1'b1, 1'b0, 0, 1'b1);
    check("t3b_sum", 32'(sum), 32'h9623);
    check("t3b_cout", 32'(cout), 32'd1);

    run_op(16'h0000, 16'h0000, 1'b1, 1'b1, 0, 1'b1);
    check("sub_borrow_sum", 32'(sum), 32'h9999);
    check("sub_borrow_cout", 32'(cout), 32'd1);

    run_op(16'h4321, 16'h1111, 1'b0, 1'b1, 5, 1'b1);
    check("t4_sum", 32'(sum), 32'h5433);
    check("t4_cout", 32'(cout), 32'd0);
    @(negedge clk);
    check("t4_not_captured_busy", 32'(busy), 32'd0);
    check("t4_idle_sum_kept", 32'(sum), 32'h5433);

    // Reset while digit 2 is about to be processed
    a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_busy_before_rst", 32'(busy), 32'd1);
    check("t5_valid_before_rst", 32'(out_valid), 32'd0);
    rst = 1'b1;
    exp_known = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_sum", 32'(sum), 32'd0);
    check("t5_cout", 32'(cout), 32'd0);
    @(negedge clk);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    run_op(16'h2468, 16'h1357, 1'b0, 1'b0, 0, 1'b1);
    check("t5_fresh_sum", 32'(sum), 32'h3825);
    check("t5_fresh_cout", 32'(cout), 32'd0);

    // Non-BCD digit passes through the same arithmetic
    run_op(16'h00A0, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    check("t6_sum", 32'(sum), 32'h0101);
    check("t6_cout", 32'(cout), 32'd0);
    run_op(16'h0010, 16'h0090, 1'b0, 1'b0, 2, 1'b1);
    check("t6_next_sum", 32'(sum), 32'h0100);

    run_op(16'h0005, 16'h0005, 1'b0, 1'b0, 1, 1'b1);
    check("carry_chain_sum", 32'(sum), 32'h0010);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
